// File: rtl/apb_slave_regfile.sv
// APB completer backed by a DEPTH x 8-bit register file with a fixed number of
// ACCESS wait states and a read-only write counter mapped at STAT_ADDR.
module apb_slave_regfile #(
  parameter int         DEPTH       = 16,
  parameter int         WAIT_STATES = 2,
  parameter logic [7:0] STAT_ADDR   = 8'hFF
) (
  input  logic       pclk,
  input  logic       prst,
  input  logic       psel,
  input  logic       penable,
  input  logic [7:0] paddr,
  input  logic       pwrite,
  input  logic [7:0] pwdata,
  output logic       pready,
  output logic [7:0] prdata,
  output logic [7:0] wr_count
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_L = 9'(DEPTH);
  localparam logic [3:0] WS      = 4'(WAIT_STATES);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic [7:0]     regs [DEPTH];
  logic           mapped;
  logic [AW-1:0]  idx;
  logic [7:0]     rd_mux;

  assign mapped = ({1'b0, paddr} < DEPTH_L);
  assign idx    = paddr[AW-1:0];

  // Completion is decoded from registered state so a zero-wait transfer
  // finishes in its first ACCESS cycle.
  assign pready = (state == S_ACCESS) && psel && penable && (cnt == 4'd0);

  always_comb begin
    rd_mux = 8'h00;
    if (mapped)
      rd_mux = regs[idx];
    else if (paddr == STAT_ADDR)
      rd_mux = wr_count;
  end

  assign prdata = (pready && !pwrite) ? rd_mux : 8'h00;

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      wr_count <= 8'h00;
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (psel && !penable) begin
            state <= S_ACCESS;
            cnt   <= WS;
          end
        end
        S_ACCESS: begin
          if (!psel) begin
            state <= S_IDLE;
          end else if (!penable) begin
            // A fresh SETUP without completion restarts the wait.
            cnt <= WS;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= S_IDLE;
            if (pwrite && mapped) begin
              regs[idx] <= pwdata;
              wr_count  <= wr_count + 8'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
